// File: rtl/bfloat16_normalizer.sv
// rtl/bfloat16_normalizer.sv - post-add normalise and round-to-nearest-even stage for bfloat16
// One unnormalised sum is accepted, shifted one bit per cycle, rounded, and held until taken.
module bfloat16_normalizer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 7
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [FRAC_W+3:0]         in_mant,
    input  logic                      in_nan,
    input  logic                      in_inf,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     result
);

    localparam int MANT_W = FRAC_W + 4;
    localparam int RES_W  = 1 + EXP_W + FRAC_W;
    localparam int CARRY  = MANT_W - 1;
    localparam int HIDDEN = MANT_W - 2;

    localparam logic [EXP_W-1:0]  EXP_MAX   = '1;
    localparam logic [EXP_W-1:0]  EXP_ONE   = EXP_W'(1);
    localparam logic [EXP_W:0]    EXP_MAX_W = {1'b0, EXP_MAX};
    localparam logic [FRAC_W-1:0] FRAC_ZERO = '0;
    localparam logic [RES_W-1:0]  QNAN      = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT_R,
        SHIFT_L,
        ROUND,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic                nan_q, nan_d;
    logic                inf_q, inf_d;
    logic                out_valid_q, out_valid_d;
    logic [RES_W-1:0]    result_q, result_d;

    logic [EXP_W:0]      exp_inc;
    logic [MANT_W-1:0]   mant_r;
    logic [MANT_W-1:0]   mant_l;
    logic [FRAC_W-1:0]   frac;
    logic                guard;
    logic                sticky;
    logic                round_up;
    logic [FRAC_W:0]     frac_sum;
    logic [RES_W-1:0]    inf_word;

    always_comb begin
        exp_inc  = {1'b0, exp_q} + {{EXP_W{1'b0}}, 1'b1};
        // Right shift folds the two bits falling off the bottom into the new sticky bit.
        mant_r   = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
        mant_l   = {mant_q[MANT_W-2:0], 1'b0};
        frac     = mant_q[FRAC_W+1:2];
        guard    = mant_q[1];
        sticky   = mant_q[0];
        round_up = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
        inf_word = {sign_q, EXP_MAX, FRAC_ZERO};
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        nan_d       = nan_q;
        inf_d       = inf_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    mant_d  = in_mant;
                    nan_d   = in_nan;
                    inf_d   = in_inf;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (nan_q) begin
                    result_d    = QNAN;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (inf_q) begin
                    result_d    = inf_word;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (mant_q == '0 || exp_q == '0) begin
                    // Exact cancellation is reported as +0 regardless of sign.
                    result_d    = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (mant_q[CARRY]) begin
                    state_d = SHIFT_R;
                end else if (mant_q[HIDDEN]) begin
                    state_d = ROUND;
                end else begin
                    state_d = SHIFT_L;
                end
            end

            SHIFT_R: begin
                mant_d = mant_r;
                exp_d  = exp_inc[EXP_W-1:0];
                if (exp_inc >= EXP_MAX_W) begin
                    result_d    = inf_word;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = ROUND;
                end
            end

            SHIFT_L: begin
                // Hidden bit is still clear here; reaching exp 1 means the value would go subnormal.
                if (exp_q == EXP_ONE) begin
                    result_d    = {sign_q, {(RES_W-1){1'b0}}};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    mant_d = mant_l;
                    exp_d  = exp_q - EXP_ONE;
                    if (mant_l[HIDDEN]) begin
                        state_d = ROUND;
                    end
                end
            end

            ROUND: begin
                if (exp_q == EXP_MAX) begin
                    result_d = inf_word;
                end else if (frac_sum[FRAC_W]) begin
                    if (exp_inc >= EXP_MAX_W) begin
                        result_d = inf_word;
                    end else begin
                        result_d = {sign_q, exp_inc[EXP_W-1:0], FRAC_ZERO};
                    end
                end else begin
                    result_d = {sign_q, exp_q, frac_sum[FRAC_W-1:0]};
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_bfloat16_normalizer.sv
// tb/tb_bfloat16_normalizer.sv - directed self-checking bench for bfloat16_normalizer
module tb_bfloat16_normalizer;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [10:0] in_mant;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int n_cmp;
    int n_bad;

    bfloat16_normalizer dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_nan    (in_nan),
        .in_inf    (in_inf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one word, count edges after the accept edge until out_valid, and
    // if out_ready is high step past the completing edge back to IDLE.
    task automatic send(input logic s, input logic [7:0] e, input logic [10:0] m,
                        input logic nan, input logic inf,
                        output int lat, output logic [15:0] res);
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_nan   = nan;
        in_inf   = inf;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        res = result;
        if (out_ready) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h00;
        in_mant   = 11'h000;
        in_nan    = 1'b0;
        in_inf    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL reset_result got %h want 0000", result); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_normalised_and_round();
        int lat;
        logic [15:0] res;
        send(1'b0, 8'd127, 11'b01_0000000_00, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h3F80) begin n_bad++; $display("FAIL norm_result got %h want 3F80", res); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL norm_latency got %0d want 2", lat); end
        send(1'b0, 8'd127, 11'b01_0000001_10, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h3F82) begin n_bad++; $display("FAIL rne_odd_tie got %h want 3F82", res); end
        send(1'b0, 8'd127, 11'b01_0000000_10, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h3F80) begin n_bad++; $display("FAIL rne_even_tie got %h want 3F80", res); end
        send(1'b0, 8'd254, 11'b01_1111111_11, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h7F80) begin n_bad++; $display("FAIL rne_overflow got %h want 7F80", res); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rne_overflow_latency got %0d want 2", lat); end
    endtask

    task automatic test_carry();
        int lat;
        logic [15:0] res;
        send(1'b0, 8'd127, 11'b10_0000000_00, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h4000) begin n_bad++; $display("FAIL carry_result got %h want 4000", res); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL carry_latency got %0d want 3", lat); end
        send(1'b0, 8'd254, 11'b10_0000000_00, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h7F80) begin n_bad++; $display("FAIL carry_overflow got %h want 7F80", res); end
        send(1'b0, 8'd127, 11'b11_0000001_10, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h4041) begin n_bad++; $display("FAIL carry_sticky_round got %h want 4041", res); end
    endtask

    task automatic test_left_shift();
        int lat;
        logic [15:0] res;
        send(1'b0, 8'd127, 11'b00_0000010_00, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h3C80) begin n_bad++; $display("FAIL lshift_result got %h want 3C80", res); end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL lshift_latency got %0d want 8", lat); end
        send(1'b0, 8'd3, 11'b00_0000010_00, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h0000) begin n_bad++; $display("FAIL underflow_result got %h want 0000", res); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL underflow_latency got %0d want 4", lat); end
        send(1'b1, 8'd3, 11'b00_0000010_00, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h8000) begin n_bad++; $display("FAIL underflow_neg got %h want 8000", res); end
    endtask

    task automatic test_specials();
        int lat;
        logic [15:0] res;
        send(1'b0, 8'd127, 11'b01_0000000_00, 1'b1, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h7FC0) begin n_bad++; $display("FAIL nan_result got %h want 7FC0", res); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL nan_latency got %0d want 1", lat); end
        send(1'b1, 8'd127, 11'b01_0000000_00, 1'b0, 1'b1, lat, res);
        n_cmp++; if (res !== 16'hFF80) begin n_bad++; $display("FAIL inf_result got %h want FF80", res); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL inf_latency got %0d want 1", lat); end
        send(1'b1, 8'd127, 11'b00_0000000_00, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h0000) begin n_bad++; $display("FAIL zero_result got %h want 0000", res); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL zero_latency got %0d want 1", lat); end
        send(1'b1, 8'd127, 11'b01_0000000_00, 1'b1, 1'b1, lat, res);
        n_cmp++; if (res !== 16'h7FC0) begin n_bad++; $display("FAIL nan_inf_result got %h want 7FC0", res); end
    endtask

    task automatic test_backpressure_and_reset();
        int lat;
        logic [15:0] res;
        out_ready = 1'b0;
        send(1'b1, 8'd130, 11'b01_1010101_00, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'hC155) begin n_bad++; $display("FAIL hold_result got %h want C155", res); end
        // A competing word offered during the hold must be ignored.
        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_mant  = 11'b01_0000000_00;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_out_valid cycle %0d got %0b want 1", i, out_valid); end
            n_cmp++; if (result !== 16'hC155) begin n_bad++; $display("FAIL hold_stable cycle %0d got %h want C155", i, result); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready cycle %0d got %0b want 0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (result !== 16'hC155) begin n_bad++; $display("FAIL release_retain got %h want C155", result); end

        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_mant  = 11'b00_0000010_00;
        in_nan   = 1'b0;
        in_inf   = 1'b0;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (result !== 16'h0000) begin n_bad++; $display("FAIL midreset_result got %h want 0000", result); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready got %0b want 1", in_ready); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL postreset_no_emit got %0b want 0", out_valid); end
        send(1'b0, 8'd128, 11'b01_1000000_00, 1'b0, 1'b0, lat, res);
        n_cmp++; if (res !== 16'h4040) begin n_bad++; $display("FAIL postreset_result got %h want 4040", res); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL postreset_latency got %0d want 2", lat); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_normalised_and_round();
        test_carry();
        test_left_shift();
        test_specials();
        test_backpressure_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
